mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: bus cycles in BUSY without bus_ack_i before the transaction is aborted.
REQ-002 Parameter ADDR_W, default 32: address width of all ports.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 arst_n  input  1  reset, synchronous, active-low.
REQ-005 if_req_i / if_addr_i  input  1 / ADDR_W  fetch read request and word address.
REQ-006 if_gnt_o / if_rvalid_o / if_rdata_o / if_err_o  output  1/1/32/1  fetch grant, response strobe, read data, error flag.
REQ-007 ls_req_i / ls_we_i / ls_addr_i / ls_wdata_i / ls_be_i  input  1/1/ADDR_W/32/4  load-store request, write flag, address, write data, byte enables.
REQ-008 ls_gnt_o / ls_rvalid_o / ls_rdata_o / ls_err_o  output  1/1/32/1  load-store grant, response strobe, read data, error flag.
REQ-009 bus_req_o / bus_we_o / bus_addr_o / bus_wdata_o / bus_be_o  output  1/1/ADDR_W/32/4  shared single-port memory command, all registered.
REQ-010 bus_ack_i / bus_rdata_i  input  1/32  memory completion strobe and read data, valid in the ack cycle.

Function
REQ-011 FSM states SHALL be IDLE, BUSY, RESP; one transaction outstanding at most.
REQ-012 IDLE: if any request is high, exactly one gnt_o SHALL assert combinationally that cycle; next state BUSY with the winner's command latched into bus_* and bus_req_o=1.
REQ-013 IDLE with no request: all gnt_o=0, stay IDLE.
REQ-014 gnt_o SHALL be 0 in BUSY and RESP; requests held high across those states are arbitrated on return to IDLE.
REQ-015 BUSY: bus_* SHALL stay stable; on bus_ack_i=1 capture bus_rdata_i (writes: capture 0), clear bus_req_o, go RESP.
REQ-016 RESP: winner's rvalid_o=1 for exactly one cycle with captured data, err_o=0; other port's rvalid_o=0; next state IDLE.
REQ-017 Latency: ack in first BUSY cycle gives rvalid two cycles after gnt; back-to-back throughput one transaction per three cycles.
REQ-018 Timeout counter SHALL clear on entering BUSY and increment each BUSY cycle without ack; on reaching TIMEOUT_CYC-1 with no ack, clear bus_req_o, go RESP with rdata=0, err_o=1.
REQ-019 Ack on the same cycle the counter reaches its limit SHALL be treated as a normal completion (err_o=0).
REQ-020 bus_ack_i in IDLE or RESP SHALL be ignored.
REQ-021 Writes SHALL produce an rvalid_o pulse (completion acknowledge) with rdata=0.
REQ-022 rdata_o/err_o of a port SHALL be 0 whenever its rvalid_o=0.

Reset
REQ-023 arst_n=0 at a rising edge SHALL force IDLE, counter 0, priority pointer to load-store, all outputs 0.
REQ-024 Reset during BUSY or RESP SHALL abandon the transaction: no rvalid_o pulse, bus_req_o low the cycle after the reset edge.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: round-robin; when both request in IDLE, grant the port not granted last; pointer updates only on grant.
REQ-026 MEM_ARB_RR_EN undefined: fixed priority, load-store always wins over fetch; no pointer register exists.

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold the state encoding (IDLE/BUSY/RESP), port index constants (PORT_IF=0, PORT_LS=1) and the 32-bit data/address width constants.
REQ-028 Grant selection SHALL live in sub-module mem_arb_pick (requests, pointer in; one-hot grant out), instantiated once.

Verification
REQ-029 Single ls read addr 0x100, ack in first BUSY cycle with data 0xDEADBEEF -> ls_gnt at T0, bus_req T1, ls_rvalid T2 with 0xDEADBEEF, err 0.
REQ-030 if_req and ls_req both high continuously, ack immediate -> fixed: all grants to LS; RR: grants alternate LS, IF, LS, IF.
REQ-031 ls write be=4'b0011 data 0x1234, ack after 5 cycles -> bus_* stable 5 cycles, ls_rvalid one pulse, rdata 0.
REQ-032 if read, no ack, TIMEOUT_CYC=8 -> bus_req drops after 8 BUSY cycles, if_rvalid=1, if_err=1, if_rdata=0.
REQ-033 arst_n low for one cycle during BUSY, then ack arrives -> no rvalid on either port, FSM IDLE, bus_req 0.
REQ-034 Stray bus_ack_i pulses in IDLE with no requests -> no rvalid, no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port
// indices and bus widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int PORT_IF    = 0;
    localparam int PORT_LS    = 1;
    localparam int DATA_W     = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int BE_W       = DATA_W / 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load-store and shared memory bus signals of the arbiter. The slave
// modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    import mem_arb_pkg::*;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_err_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic [BE_W-1:0]   ls_be_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;
    logic              ls_err_o;

    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [BE_W-1:0]   bus_be_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output bus_ack_i, bus_rdata_i
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way grant selection: a lone requester wins, a tie goes to the port
// named by ptr. Output is one-hot (or zero with no requests).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[PORT_LS] && req[PORT_IF]) begin
            gnt[ptr] = 1'b1;
        end else if (req[PORT_LS]) begin
            gnt[PORT_LS] = 1'b1;
        end else if (req[PORT_IF]) begin
            gnt[PORT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load-store ports onto one single-port memory bus.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed LS priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int ADDR_W      = ADDR_WIDTH
) (
    input logic          clk,
    input logic          arst_n,
    mem_arbiter_if.slave arb
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t        state;
    logic              winner;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [1:0]        req;
    logic [1:0]        pick_gnt;
    logic              pick_ptr;
    logic              grant_en;
    logic              sel_ls;
    logic [ADDR_W-1:0] sel_addr;
    logic              resp_fire;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;

    assign req[PORT_IF] = arb.if_req_i;
    assign req[PORT_LS] = arb.ls_req_i;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;
    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = 1'(PORT_LS);
`endif

    mem_arb_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    // Grants are only offered from IDLE and never while reset is applied.
    assign grant_en     = (state == IDLE) && arst_n;
    assign arb.if_gnt_o = grant_en && pick_gnt[PORT_IF];
    assign arb.ls_gnt_o = grant_en && pick_gnt[PORT_LS];
    assign sel_ls       = pick_gnt[PORT_LS];
    assign sel_addr     = sel_ls ? arb.ls_addr_i : arb.if_addr_i;

    // An ack on the final timeout cycle still counts as a normal completion.
    assign resp_fire = arb.bus_ack_i || (tmo_cnt == TMO_LAST);
    assign resp_err  = !arb.bus_ack_i;
    assign resp_data = (arb.bus_ack_i && !arb.bus_we_o) ? arb.bus_rdata_i : '0;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state           <= IDLE;
            winner          <= 1'(PORT_LS);
            tmo_cnt         <= '0;
            arb.bus_req_o   <= 1'b0;
            arb.bus_we_o    <= 1'b0;
            arb.bus_addr_o  <= '0;
            arb.bus_wdata_o <= '0;
            arb.bus_be_o    <= '0;
            arb.if_rvalid_o <= 1'b0;
            arb.if_rdata_o  <= '0;
            arb.if_err_o    <= 1'b0;
            arb.ls_rvalid_o <= 1'b0;
            arb.ls_rdata_o  <= '0;
            arb.ls_err_o    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_ptr          <= 1'(PORT_LS);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state           <= BUSY;
                        winner          <= sel_ls;
                        tmo_cnt         <= '0;
                        arb.bus_req_o   <= 1'b1;
                        arb.bus_we_o    <= sel_ls && arb.ls_we_i;
                        arb.bus_addr_o  <= sel_addr;
                        arb.bus_wdata_o <= sel_ls ? arb.ls_wdata_i : '0;
                        arb.bus_be_o    <= sel_ls ? arb.ls_be_i : '1;
`ifdef MEM_ARB_RR_EN
                        rr_ptr          <= sel_ls ? 1'(PORT_IF) : 1'(PORT_LS);
`endif
                    end
                end
                BUSY: begin
                    if (resp_fire) begin
                        state           <= RESP;
                        arb.bus_req_o   <= 1'b0;
                        arb.if_rvalid_o <= (winner == 1'(PORT_IF));
                        arb.if_rdata_o  <= (winner == 1'(PORT_IF)) ? resp_data : '0;
                        arb.if_err_o    <= (winner == 1'(PORT_IF)) && resp_err;
                        arb.ls_rvalid_o <= (winner == 1'(PORT_LS));
                        arb.ls_rdata_o  <= (winner == 1'(PORT_LS)) ? resp_data : '0;
                        arb.ls_err_o    <= (winner == 1'(PORT_LS)) && resp_err;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state           <= IDLE;
                    arb.if_rvalid_o <= 1'b0;
                    arb.if_rdata_o  <= '0;
                    arb.if_err_o    <= 1'b0;
                    arb.ls_rvalid_o <= 1'b0;
                    arb.ls_rdata_o  <= '0;
                    arb.ls_err_o    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (TIMEOUT_CYC=8). Stimulus pushes expected
// grants/responses; monitors pop and compare them whenever the DUT shows one.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int   TMO  = 8;
    localparam logic P_IF = 1'(PORT_IF);
    localparam logic P_LS = 1'(PORT_LS);

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic  clk;
    logic  arst_n;
    logic  mon_en;
    int    n_checks;
    int    n_fail;
    resp_t exp_resp[$];
    logic  exp_gnt[$];

    mem_arbiter_if #(.ADDR_W(32)) arb_if ();

    mem_arbiter #(.TIMEOUT_CYC(TMO), .ADDR_W(32)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .arb    (arb_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        if (port == P_LS) begin
            arb_if.ls_req_i   = 1'b1;
            arb_if.ls_we_i    = we;
            arb_if.ls_addr_i  = addr;
            arb_if.ls_wdata_i = wdata;
            arb_if.ls_be_i    = be;
        end else begin
            arb_if.if_req_i  = 1'b1;
            arb_if.if_addr_i = addr;
        end
    endtask

    task automatic dropRequests();
        arb_if.if_req_i = 1'b0;
        arb_if.ls_req_i = 1'b0;
    endtask

    task automatic pushExpect(input logic port, input logic [31:0] data, input logic err);
        resp_t r;
        r.port = port;
        r.data = data;
        r.err  = err;
        exp_resp.push_back(r);
    endtask

    task automatic checkBus(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        checkOutput("bus_req_busy", arb_if.bus_req_o, 1);
        checkOutput("bus_addr", arb_if.bus_addr_o, addr);
        checkOutput("bus_we", arb_if.bus_we_o, (port == P_LS) && we);
        checkOutput("bus_wdata", arb_if.bus_wdata_o, (port == P_LS) ? wdata : 32'h0);
        if (port == P_LS) checkOutput("bus_be", arb_if.bus_be_o, be);
    endtask

    // Called just after a posedge with the DUT in IDLE; returns just after
    // the posedge that brings it back to IDLE.
    task automatic runTxn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int delay, input logic [31:0] mem_data);
        exp_gnt.push_back(port);
        pushExpect(port, we ? 32'h0 : mem_data, 1'b0);
        applyStimulus(port, we, addr, wdata, be);
        @(negedge clk);
        checkOutput("gnt_same_cycle", {arb_if.ls_gnt_o, arb_if.if_gnt_o}, (port == P_LS) ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        dropRequests();
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkBus(port, we, addr, wdata, be);
            @(posedge clk); #1;
        end
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = mem_data;
        @(negedge clk);
        checkBus(port, we, addr, wdata, be);
        @(posedge clk); #1;
        arb_if.bus_ack_i   = 1'b0;
        arb_if.bus_rdata_i = 32'h0;
        @(negedge clk);
        checkOutput("rvalid_after_ack", (port == P_LS) ? arb_if.ls_rvalid_o : arb_if.if_rvalid_o, 1);
        checkOutput("bus_req_cleared", arb_if.bus_req_o, 0);
        @(posedge clk); #1;
    endtask

    // Response scoreboard plus "data/err quiet while rvalid low" checks.
    always @(negedge clk) begin
        if (mon_en) begin
            if (arb_if.if_rvalid_o || arb_if.ls_rvalid_o) begin
                if (exp_resp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rvalid: got if=%0b ls=%0b expected none at %0t",
                             arb_if.if_rvalid_o, arb_if.ls_rvalid_o, $time);
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    checkOutput("resp_port", {arb_if.ls_rvalid_o, arb_if.if_rvalid_o},
                                (e.port == P_LS) ? 2'b10 : 2'b01);
                    checkOutput("resp_rdata", (e.port == P_LS) ? arb_if.ls_rdata_o : arb_if.if_rdata_o, e.data);
                    checkOutput("resp_err", (e.port == P_LS) ? arb_if.ls_err_o : arb_if.if_err_o, e.err);
                end
            end
            if (!arb_if.if_rvalid_o) checkOutput("if_quiet", {arb_if.if_err_o, arb_if.if_rdata_o}, 0);
            if (!arb_if.ls_rvalid_o) checkOutput("ls_quiet", {arb_if.ls_err_o, arb_if.ls_rdata_o}, 0);
        end
    end

    // Grant scoreboard.
    always @(negedge clk) begin
        if (mon_en && (arb_if.if_gnt_o || arb_if.ls_gnt_o)) begin
            if (exp_gnt.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_gnt: got if=%0b ls=%0b expected none at %0t",
                         arb_if.if_gnt_o, arb_if.ls_gnt_o, $time);
            end else begin
                logic g;
                g = exp_gnt.pop_front();
                checkOutput("gnt_port", {arb_if.ls_gnt_o, arb_if.if_gnt_o}, (g == P_LS) ? 2'b10 : 2'b01);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before %0t", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int   busy;
        logic p;
        clk = 1'b0;
        arst_n = 1'b0;
        mon_en = 1'b0;
        n_checks = 0;
        n_fail = 0;
        arb_if.if_req_i = 0; arb_if.if_addr_i = 0;
        arb_if.ls_req_i = 0; arb_if.ls_we_i = 0; arb_if.ls_addr_i = 0;
        arb_if.ls_wdata_i = 0; arb_if.ls_be_i = 0;
        arb_if.bus_ack_i = 0; arb_if.bus_rdata_i = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_bus_req", arb_if.bus_req_o, 0);
        checkOutput("rst_bus_cmd", {arb_if.bus_we_o, arb_if.bus_be_o, arb_if.bus_addr_o}, 0);
        checkOutput("rst_rvalid", {arb_if.if_rvalid_o, arb_if.ls_rvalid_o}, 0);
        checkOutput("rst_gnt", {arb_if.if_gnt_o, arb_if.ls_gnt_o}, 0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        mon_en = 1'b1;

        $display("[TB] both ports requesting continuously");
        applyStimulus(P_IF, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        applyStimulus(P_LS, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            p = (k % 2 == 0) ? P_LS : P_IF;
`else
            p = P_LS;
`endif
            exp_gnt.push_back(p);
            pushExpect(p, 32'hA000_0000 + 32'(k), 1'b0);
            @(negedge clk);
            checkOutput("arb_gnt", {arb_if.ls_gnt_o, arb_if.if_gnt_o}, (p == P_LS) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            arb_if.bus_ack_i   = 1'b1;
            arb_if.bus_rdata_i = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            checkOutput("arb_addr", arb_if.bus_addr_o, (p == P_LS) ? 32'h0000_2000 : 32'h0000_1000);
            @(posedge clk); #1;
            arb_if.bus_ack_i   = 1'b0;
            arb_if.bus_rdata_i = 32'h0;
            @(negedge clk);
            checkOutput("arb_no_gnt_resp", {arb_if.ls_gnt_o, arb_if.if_gnt_o}, 0);
            @(posedge clk); #1;
        end
        dropRequests();

        $display("[TB] single ls read, immediate ack");
        runTxn(P_LS, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 32'hDEAD_BEEF);

        $display("[TB] ls write, ack after 5 cycles");
        runTxn(P_LS, 1'b1, 32'h0000_0200, 32'h0000_1234, 4'b0011, 5, 32'hFFFF_FFFF);

        $display("[TB] fetch read, ack after 2 cycles");
        runTxn(P_IF, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 32'hCAFE_0001);

        $display("[TB] ack on final timeout cycle");
        runTxn(P_IF, 1'b0, 32'h0000_0300, 32'h0, 4'hF, TMO - 1, 32'h0BAD_F00D);

        $display("[TB] fetch read timeout");
        exp_gnt.push_back(P_IF);
        pushExpect(P_IF, 32'h0, 1'b1);
        applyStimulus(P_IF, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        @(negedge clk);
        @(posedge clk); #1;
        dropRequests();
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!arb_if.bus_req_o) break;
            busy++;
        end
        checkOutput("tmo_busy_cycles", busy, TMO);
        checkOutput("tmo_if_rvalid", arb_if.if_rvalid_o, 1);
        checkOutput("tmo_if_err", arb_if.if_err_o, 1);
        checkOutput("tmo_if_rdata", arb_if.if_rdata_o, 0);
        @(posedge clk); #1;

        $display("[TB] reset during BUSY");
        exp_gnt.push_back(P_IF);
        applyStimulus(P_IF, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
        @(negedge clk);
        @(posedge clk); #1;
        dropRequests();
        @(negedge clk);
        checkOutput("rst_busy_req", arb_if.bus_req_o, 1);
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'h0000_0077;
        @(negedge clk);
        checkOutput("rst_abort_req", arb_if.bus_req_o, 0);
        checkOutput("rst_abort_rvalid", {arb_if.if_rvalid_o, arb_if.ls_rvalid_o}, 0);
        @(posedge clk); #1;
        arb_if.bus_ack_i   = 1'b0;
        arb_if.bus_rdata_i = 32'h0;
        @(negedge clk);
        checkOutput("rst_abort_rvalid2", {arb_if.if_rvalid_o, arb_if.ls_rvalid_o}, 0);
        @(posedge clk); #1;

        $display("[TB] stray acks in IDLE");
        for (int i = 0; i < 3; i++) begin
            arb_if.bus_ack_i   = 1'b1;
            arb_if.bus_rdata_i = 32'hFFFF_0000 + 32'(i);
            @(negedge clk);
            checkOutput("stray_bus_req", arb_if.bus_req_o, 0);
            checkOutput("stray_rvalid", {arb_if.if_rvalid_o, arb_if.ls_rvalid_o}, 0);
            @(posedge clk); #1;
        end
        arb_if.bus_ack_i   = 1'b0;
        arb_if.bus_rdata_i = 32'h0;
        runTxn(P_IF, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 1, 32'h5555_AAAA);

        repeat (2) @(posedge clk);
        checkOutput("resp_queue_empty", exp_resp.size(), 0);
        checkOutput("gnt_queue_empty", exp_gnt.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
